// File: rtl/mc_delay_pkg.sv
// Shared helpers for the multicycle data-delay block: width math and
// parameter legality checks used at elaboration time.
package mc_delay_pkg;

    localparam int MIN_RATIO    = 2;
    localparam int MAX_RATIO    = 16;
    localparam int MIN_DEPTH    = 1;
    localparam int MAX_DEPTH    = 8;
    localparam int MIN_CHANNELS = 1;
    localparam int MAX_CHANNELS = 8;

    // Ceiling log2; returns 0 for values of 1 or less.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of the phase counter; never narrower than one bit.
    function automatic int phase_w(input int ratio);
        return (clog2(ratio) < 1) ? 1 : clog2(ratio);
    endfunction

    // True when the configuration can be built.
    function automatic bit params_ok(input int ratio, input int depth,
                                     input int capture_phase, input int channels);
        return (ratio >= MIN_RATIO) && (ratio <= MAX_RATIO) &&
               (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) &&
               (channels >= MIN_CHANNELS) && (channels <= MAX_CHANNELS) &&
               (capture_phase >= 0) && (capture_phase <= ratio - 2);
    endfunction

endpackage

// File: rtl/mc_phase_gen.sv
// Phase counter for the divide-by-RATIO slow pipeline. Produces the slow
// tick, the mid-stage capture enable and a registered strobe aligned with
// the first cycle of each new slow-rate output word.
module mc_phase_gen
    import mc_delay_pkg::*;
#(
    parameter int RATIO         = 2,
    parameter int CAPTURE_PHASE = 0
) (
    input  logic                        pll_clock,
    input  logic                        reset,
    input  logic                        phase_clr,
    output logic [phase_w(RATIO)-1:0]   phase,
    output logic                        tick,
    output logic                        capture,
    output logic                        strobe
);

    localparam int PW = phase_w(RATIO);
    localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);
    localparam logic [PW-1:0] CAP_PHASE  = PW'(CAPTURE_PHASE);

    logic [PW-1:0] cnt_reg;
    logic [PW-1:0] cnt_next;
    logic          strobe_reg;

    assign tick    = (cnt_reg == LAST_PHASE);
    assign capture = (cnt_reg == CAP_PHASE);
    assign phase   = cnt_reg;
    assign strobe  = strobe_reg;

    // Next phase: realign wins over the wrap/increment.
    always_comb begin
        cnt_next = cnt_reg + PW'(1);
        if (phase_clr) begin
            cnt_next = '0;
        end else if (tick) begin
            cnt_next = '0;
        end
    end

    // Counter and strobe registers; strobe follows tick by one cycle.
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            cnt_reg    <= '0;
            strobe_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            strobe_reg <= tick;
        end
    end

endmodule

// File: rtl/mc_data_delay_n.sv
// Multicycle data-delay block: a fast input stage, a mid stage loaded at
// CAPTURE_PHASE and a DEPTH-deep slow pipeline advanced on each slow tick.
// Every lane shares one phase generator; valid travels in its own chain.
// CAPTURE_PHASE defaults to 0 because it must not exceed RATIO-2.
module mc_data_delay_n
    import mc_delay_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int CHANNELS      = 1,
    parameter int RATIO         = 2,
    parameter int DEPTH         = 1,
    parameter int CAPTURE_PHASE = 0
) (
    input  logic                         pll_clock,
    input  logic                         reset,
    input  logic                         phase_clr,
    input  logic [WIDTH*CHANNELS-1:0]    data_in,
    input  logic                         valid_in,
    output logic [WIDTH*CHANNELS-1:0]    data_out,
    output logic                         valid_out,
    output logic                         strobe_out,
    output logic [phase_w(RATIO)-1:0]    phase
);

    if (!params_ok(RATIO, DEPTH, CAPTURE_PHASE, CHANNELS)) begin : g_bad_params
        $error("mc_data_delay_n: illegal RATIO/DEPTH/CAPTURE_PHASE/CHANNELS");
    end

    logic tick;
    logic capture;

    mc_phase_gen #(
        .RATIO         (RATIO),
        .CAPTURE_PHASE (CAPTURE_PHASE)
    ) u_phase_gen (
        .pll_clock (pll_clock),
        .reset     (reset),
        .phase_clr (phase_clr),
        .phase     (phase),
        .tick      (tick),
        .capture   (capture),
        .strobe    (strobe_out)
    );

    (* preserve, shreg_extract = "no" *) logic vfast_reg;
    (* preserve, shreg_extract = "no" *) logic vmid_reg;

    // Valid fast and mid stages.
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            vfast_reg <= 1'b0;
            vmid_reg  <= 1'b0;
        end else begin
            vfast_reg <= valid_in;
            if (capture) begin
                vmid_reg <= vfast_reg;
            end
        end
    end

    // Valid slow chain, parallel to the data chain.
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_vstage
        (* preserve, shreg_extract = "no" *) logic q_reg;
        if (gj == 0) begin : g_first
            // First slow valid stage loads from mid on tick.
            always_ff @(posedge pll_clock) begin
                if (reset) begin
                    q_reg <= 1'b0;
                end else if (tick) begin
                    q_reg <= vmid_reg;
                end
            end
        end else begin : g_next
            // Later slow valid stages shift on tick.
            always_ff @(posedge pll_clock) begin
                if (reset) begin
                    q_reg <= 1'b0;
                end else if (tick) begin
                    q_reg <= g_vstage[gj-1].q_reg;
                end
            end
        end
    end

    assign valid_out = g_vstage[DEPTH-1].q_reg;

    // Independent data lanes, all timed by the shared tick/capture.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        (* preserve, shreg_extract = "no" *) logic [WIDTH-1:0] fast_reg;
        (* preserve, shreg_extract = "no" *) logic [WIDTH-1:0] mid_reg;

        // Fast stage samples every cycle; mid takes it at the capture phase.
        always_ff @(posedge pll_clock) begin
            if (reset) begin
                fast_reg <= '0;
                mid_reg  <= '0;
            end else begin
                fast_reg <= data_in[gi*WIDTH +: WIDTH];
                if (capture) begin
                    mid_reg <= fast_reg;
                end
            end
        end

        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_stage
            (* preserve, shreg_extract = "no" *) logic [WIDTH-1:0] q_reg;
            if (gj == 0) begin : g_first
                // First slow data stage loads from mid on tick.
                always_ff @(posedge pll_clock) begin
                    if (reset) begin
                        q_reg <= '0;
                    end else if (tick) begin
                        q_reg <= mid_reg;
                    end
                end
            end else begin : g_next
                // Later slow data stages shift on tick.
                always_ff @(posedge pll_clock) begin
                    if (reset) begin
                        q_reg <= '0;
                    end else if (tick) begin
                        q_reg <= g_stage[gj-1].q_reg;
                    end
                end
            end
        end

        assign data_out[gi*WIDTH +: WIDTH] = g_stage[DEPTH-1].q_reg;
    end

endmodule

// File: tb/tb_mc_data_delay_n.sv
// Bench for mc_data_delay_n: three configurations share one stimulus
// stream; a time-indexed sample history plus per-configuration slow-word
// queues predict every output each cycle, alongside directed checks.
module tb_mc_data_delay_n;

    localparam int NI = 3;
    localparam int M_R  [NI] = '{4, 4, 8};
    localparam int M_CP [NI] = '{1, 1, 0};
    localparam int M_D  [NI] = '{1, 3, 1};

    logic        pll_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        phase_clr = 1'b0;
    logic [31:0] data_in   = '0;
    logic        valid_in  = 1'b0;

    logic [31:0] do_a, do_b, do_c;
    logic        vo_a, vo_b, vo_c;
    logic        so_a, so_b, so_c;
    logic [1:0]  ph_a, ph_b;
    logic [2:0]  ph_c;

    always #5 pll_clock = ~pll_clock;

    mc_data_delay_n #(.WIDTH(16), .CHANNELS(2), .RATIO(4), .DEPTH(1), .CAPTURE_PHASE(1)) dut_a (
        .pll_clock(pll_clock), .reset(reset), .phase_clr(phase_clr), .data_in(data_in),
        .valid_in(valid_in), .data_out(do_a), .valid_out(vo_a), .strobe_out(so_a), .phase(ph_a));
    mc_data_delay_n #(.WIDTH(16), .CHANNELS(2), .RATIO(4), .DEPTH(3), .CAPTURE_PHASE(1)) dut_b (
        .pll_clock(pll_clock), .reset(reset), .phase_clr(phase_clr), .data_in(data_in),
        .valid_in(valid_in), .data_out(do_b), .valid_out(vo_b), .strobe_out(so_b), .phase(ph_b));
    mc_data_delay_n #(.WIDTH(16), .CHANNELS(2), .RATIO(8), .DEPTH(1), .CAPTURE_PHASE(0)) dut_c (
        .pll_clock(pll_clock), .reset(reset), .phase_clr(phase_clr), .data_in(data_in),
        .valid_in(valid_in), .data_out(do_c), .valid_out(vo_c), .strobe_out(so_c), .phase(ph_c));

    logic [31:0] o_d  [NI];
    logic        o_v  [NI];
    logic        o_s  [NI];
    logic [3:0]  o_ph [NI];
    assign o_d[0] = do_a;  assign o_d[1] = do_b;  assign o_d[2] = do_c;
    assign o_v[0] = vo_a;  assign o_v[1] = vo_b;  assign o_v[2] = vo_c;
    assign o_s[0] = so_a;  assign o_s[1] = so_b;  assign o_s[2] = so_c;
    assign o_ph[0] = {2'b00, ph_a};
    assign o_ph[1] = {2'b00, ph_b};
    assign o_ph[2] = {1'b0, ph_c};

    int errors = 0;
    int checks = 0;

    // Reference model: hist[t] is what the fast stage holds after cycle t;
    // each configuration keeps its phase, the word selected for the next
    // slow tick, and a queue of slow words whose oldest entry is data_out.
    logic [32:0] hist [0:4095];
    int          t;
    int          m_cnt    [NI];
    logic [32:0] m_mid    [NI];
    logic        m_strobe [NI];
    logic [32:0] pipe_q   [NI][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_cnt[i]    = 0;
        m_mid[i]    = '0;
        m_strobe[i] = 1'b0;
        pipe_q[i].delete();
        for (int k = 0; k < M_D[i]; k++) pipe_q[i].push_back(33'd0);
    endtask

    task automatic model_update(input logic r, input logic c, input logic [31:0] d, input logic v);
        hist[t] = r ? 33'd0 : {v, d};
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                model_reset(i);
            end else begin
                if (m_cnt[i] == M_CP[i]) m_mid[i] = hist[t-1];
                if (m_cnt[i] == M_R[i] - 1) begin
                    pipe_q[i].push_front(m_mid[i]);
                    void'(pipe_q[i].pop_back());
                    m_strobe[i] = 1'b1;
                end else begin
                    m_strobe[i] = 1'b0;
                end
                m_cnt[i] = c ? 0 : (m_cnt[i] + 1) % M_R[i];
            end
        end
        t++;
    endtask

    // One clock cycle: drive, compare every output with the model, advance.
    task automatic step(input logic r, input logic c, input logic [31:0] d, input logic v);
        logic [32:0] e;
        @(posedge pll_clock);
        #1;
        reset = r; phase_clr = c; data_in = d; valid_in = v;
        @(negedge pll_clock);
        for (int i = 0; i < NI; i++) begin
            e = pipe_q[i][M_D[i]-1];
            chk($sformatf("m%0d_data t=%0d", i, t), o_d[i], e[31:0]);
            chk($sformatf("m%0d_valid t=%0d", i, t), {31'd0, o_v[i]}, {31'd0, e[32]});
            chk($sformatf("m%0d_strobe t=%0d", i, t), {31'd0, o_s[i]}, {31'd0, m_strobe[i]});
            chk($sformatf("m%0d_phase t=%0d", i, t), {28'd0, o_ph[i]}, m_cnt[i]);
        end
        $display("cyc %0d rst=%0b clr=%0b din=%h v=%0b | a=%h/%0b/%0b b=%h/%0b/%0b c=%h/%0b/%0b",
                 t, r, c, d, v, do_a, vo_a, so_a, do_b, vo_b, so_b, do_c, vo_c, so_c);
        model_update(r, c, d, v);
    endtask

    function automatic logic [31:0] pat(input int k);
        logic [15:0] lo;
        lo = 16'h0100 + 16'(k);
        return {~lo, lo};
    endfunction

    initial begin
        hist[0] = '0;
        t = 1;
        for (int i = 0; i < NI; i++) model_reset(i);

        // Reset state
        repeat (3) step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        chk("rst_a_data", do_a, 32'd0);
        chk("rst_b_data", do_b, 32'd0);
        chk("rst_c_data", do_c, 32'd0);
        chk("rst_valid", {29'd0, vo_a, vo_b, vo_c}, 32'd0);
        chk("rst_strobe", {29'd0, so_a, so_b, so_c}, 32'd0);

        // Basic latency, deep pipeline and capture phase 0 with two lanes
        for (int k = 0; k <= 16; k++) begin
            step(1'b0, 1'b0, pat(k), 1'b1);
            if (k < 4)  chk("basic_a_early", do_a, 32'd0);
            if (k == 3) chk("basic_a_valid_low", {31'd0, vo_a}, 32'd0);
            if (k == 4) chk("basic_a_first", do_a, pat(0));
            if (k == 4) chk("basic_a_valid_rise", {31'd0, vo_a}, 32'd1);
            if (k == 8) chk("basic_a_second", do_a, pat(4));
            if (k == 4 || k == 8 || k == 12) chk("basic_a_strobe", {31'd0, so_a}, 32'd1);
            if (k == 11) chk("deep_b_early", do_b, 32'd0);
            if (k == 12) chk("deep_b_first", do_b, pat(0));
            if (k == 16) chk("deep_b_second", do_b, pat(4));
            if (k == 8)  chk("cp0_c_strobe", {31'd0, so_c}, 32'd1);
            if (k == 8)  chk("cp0_c_zero", do_c, 32'd0);
            if (k == 16) chk("cp0_c_sample7", do_c, pat(7));
        end

        // phase_clr at cycle 6
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k <= 12; k++) begin
            step(1'b0, (k == 6), pat(k), 1'b1);
            if (k == 7)  chk("clr_a_phase0", {30'd0, ph_a}, 32'd0);
            if (k == 7)  chk("clr_a_no_strobe", {31'd0, so_a}, 32'd0);
            if (k == 11) chk("clr_a_strobe", {31'd0, so_a}, 32'd1);
            if (k == 11) chk("clr_a_data", do_a, pat(7));
        end

        // Reset in the middle of operation
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k <= 16; k++) begin
            step((k == 10), 1'b0, pat(k), 1'b1);
            if (k == 11) chk("mrst_a_data", do_a, 32'd0);
            if (k == 11) chk("mrst_a_vs", {30'd0, vo_a, so_a}, 32'd0);
            if (k == 11) chk("mrst_a_phase", {30'd0, ph_a}, 32'd0);
            if (k == 15) chk("mrst_a_restart", do_a, pat(11));
        end

        // Valid tracking: single valid sample at cycle 4
        step(1'b1, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k <= 13; k++) begin
            step(1'b0, 1'b0, pat(k), (k == 4));
            chk($sformatf("vld_a_valid k=%0d", k), {31'd0, vo_a}, {31'd0, (k >= 8 && k <= 11)});
            if (k >= 8 && k <= 11) chk("vld_a_data", do_a, pat(4));
        end

        // Randomized traffic with occasional realign and reset
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
